// File: rtl/timer_loader_if.sv
// timer_loader_if: writer/reader link between the timer loader and the mod-10 digit chain
// Signals: sec_ones/sec_tens/min_ones load digits, loadn active-low load strobe,
//          en count enable, timer_zero zero flag of the most-significant counter.
// Modports: master = loader side, slave = counter chain side.
interface timer_loader_if;
  logic [3:0] sec_ones, sec_tens, min_ones;
  logic loadn, en, timer_zero;
  modport master (output sec_ones, sec_tens, min_ones, loadn, en, input timer_zero);
  modport slave (input sec_ones, sec_tens, min_ones, loadn, en, output timer_zero);
endinterface

// File: rtl/timer_loader.sv
// timer_loader: captures M:SS key entry and loads/starts the down-counting digit chain
// Ports: clk, clrn (async active-low reset), key_code/key_valid (keypad, press = rising edge),
//        start/cancel (level requests), busy (LOAD or RUN), done (one-cycle completion pulse),
//        chain (timer_loader_if.master: digits, loadn, en out; timer_zero in).
// Build option: define LOADER_SEC_CLAMP_EN to clamp seconds above 59 to 59 when loading.
module timer_loader (
  input  logic       clk,
  input  logic       clrn,
  input  logic [3:0] key_code,
  input  logic       key_valid,
  input  logic       start,
  input  logic       cancel,
  output logic       busy,
  output logic       done,
  timer_loader_if.master chain
);
  typedef enum logic [1:0] {IDLE, ENTRY, LOAD, RUN} state_t;
  state_t state, state_n;
  logic [3:0] so, st, mo, so_n, st_n, mo_n;
  logic key_prev, press, loadn, en;
  assign press = key_valid && !key_prev && key_code <= 4'd9;
  always_comb begin
    state_n = state;
    so_n = so;
    st_n = st;
    mo_n = mo;
    case (state)
      IDLE:
        if (press) begin
          state_n = ENTRY;
          mo_n = st;
          st_n = so;
          so_n = key_code;
        end
      ENTRY:
        if (cancel) begin
          state_n = IDLE;
          mo_n = 4'd0;
          st_n = 4'd0;
          so_n = 4'd0;
        end else if (start && {mo, st, so} != 12'd0) begin
          state_n = LOAD;
`ifdef LOADER_SEC_CLAMP_EN
          if (st > 4'd5) begin
            st_n = 4'd5;
            so_n = 4'd9;
          end
`endif
        end else if (press) begin
          mo_n = st;
          st_n = so;
          so_n = key_code;
        end
      LOAD: state_n = RUN;
      RUN:
        // zero wins over cancel so a coincident abort still reports completion
        if (chain.timer_zero || cancel) begin
          state_n = IDLE;
          mo_n = 4'd0;
          st_n = 4'd0;
          so_n = 4'd0;
        end
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge clrn)
    if (!clrn) begin
      state <= IDLE;
      so <= 4'd0;
      st <= 4'd0;
      mo <= 4'd0;
      key_prev <= 1'b0;
      loadn <= 1'b1;
      en <= 1'b0;
      busy <= 1'b0;
      done <= 1'b0;
    end else begin
      state <= state_n;
      so <= so_n;
      st <= st_n;
      mo <= mo_n;
      key_prev <= key_valid;
      loadn <= state_n != LOAD;
      en <= state_n == RUN;
      busy <= state_n == LOAD || state_n == RUN;
      done <= state == RUN && chain.timer_zero;
    end
  assign chain.sec_ones = so;
  assign chain.sec_tens = st;
  assign chain.min_ones = mo;
  assign chain.loadn = loadn;
  assign chain.en = en;
endmodule

// File: tb/tb_timer_loader.sv
// tb_timer_loader: directed self-checking bench for timer_loader
module tb_timer_loader;
  logic clk = 0, clrn = 0, key_valid = 0, start = 0, cancel = 0;
  logic [3:0] key_code = 0;
  logic busy, done;
  logic [11:0] digits;
  logic [3:0] ctl;
  int checks = 0, errors = 0;
  timer_loader_if chain ();
  timer_loader dut (
    .clk(clk), .clrn(clrn), .key_code(key_code), .key_valid(key_valid),
    .start(start), .cancel(cancel), .busy(busy), .done(done), .chain(chain)
  );
  always #5 clk = ~clk;
  assign digits = {chain.min_ones, chain.sec_tens, chain.sec_ones};
  assign ctl = {chain.loadn, chain.en, busy, done};
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic press(input logic [3:0] k);
    key_code = k;
    key_valid = 1;
    tick;
    key_valid = 0;
    tick;
  endtask
  task automatic test_reset;
    clrn = 0;
    chain.timer_zero = 0;
    repeat (2) tick;
    checks++; if (ctl !== 4'b1000) begin errors++; $display("FAIL reset_ctl got %b want %b", ctl, 4'b1000); end
    checks++; if (digits !== 12'h000) begin errors++; $display("FAIL reset_digits got %h want %h", digits, 12'h000); end
    clrn = 1;
    tick;
  endtask
  task automatic test_basic_run;
    press(1); press(2); press(3);
    checks++; if (digits !== 12'h123) begin errors++; $display("FAIL basic_entry got %h want %h", digits, 12'h123); end
    start = 1; tick; start = 0;
    checks++; if (ctl !== 4'b0010) begin errors++; $display("FAIL basic_load_ctl got %b want %b", ctl, 4'b0010); end
    checks++; if (digits !== 12'h123) begin errors++; $display("FAIL basic_load_digits got %h want %h", digits, 12'h123); end
    tick;
    checks++; if (ctl !== 4'b1110) begin errors++; $display("FAIL basic_run_ctl got %b want %b", ctl, 4'b1110); end
    tick;
    checks++; if (ctl !== 4'b1110) begin errors++; $display("FAIL basic_run2_ctl got %b want %b", ctl, 4'b1110); end
    chain.timer_zero = 1; tick; chain.timer_zero = 0;
    checks++; if (ctl !== 4'b1001) begin errors++; $display("FAIL basic_done_ctl got %b want %b", ctl, 4'b1001); end
    checks++; if (digits !== 12'h000) begin errors++; $display("FAIL basic_done_digits got %h want %h", digits, 12'h000); end
    tick;
    checks++; if (ctl !== 4'b1000) begin errors++; $display("FAIL basic_done_pulse got %b want %b", ctl, 4'b1000); end
  endtask
  task automatic test_keys;
    key_code = 7; key_valid = 1;
    repeat (5) tick;
    key_valid = 0; tick;
    checks++; if (digits !== 12'h007) begin errors++; $display("FAIL key_hold got %h want %h", digits, 12'h007); end
    press(12);
    checks++; if (digits !== 12'h007) begin errors++; $display("FAIL key_invalid got %h want %h", digits, 12'h007); end
    press(4); press(5); press(6); press(7);
    checks++; if (digits !== 12'h567) begin errors++; $display("FAIL key_shift got %h want %h", digits, 12'h567); end
    cancel = 1; tick; cancel = 0;
    checks++; if (digits !== 12'h000) begin errors++; $display("FAIL entry_cancel got %h want %h", digits, 12'h000); end
  endtask
  task automatic test_guards;
    start = 1; tick; start = 0;
    checks++; if (ctl !== 4'b1000) begin errors++; $display("FAIL start_idle got %b want %b", ctl, 4'b1000); end
    press(0);
    start = 1; tick; start = 0;
    checks++; if (ctl !== 4'b1000) begin errors++; $display("FAIL start_zero got %b want %b", ctl, 4'b1000); end
    press(3);
    checks++; if (digits !== 12'h003) begin errors++; $display("FAIL guard_entry got %h want %h", digits, 12'h003); end
    start = 1; cancel = 1; tick; start = 0; cancel = 0;
    checks++; if (ctl !== 4'b1000) begin errors++; $display("FAIL start_cancel_ctl got %b want %b", ctl, 4'b1000); end
    checks++; if (digits !== 12'h000) begin errors++; $display("FAIL start_cancel_digits got %h want %h", digits, 12'h000); end
    tick;
    checks++; if (ctl !== 4'b1000) begin errors++; $display("FAIL start_cancel_late got %b want %b", ctl, 4'b1000); end
  endtask
  task automatic test_abort;
    press(2);
    start = 1; tick; start = 0; tick;
    checks++; if (ctl !== 4'b1110) begin errors++; $display("FAIL abort_run got %b want %b", ctl, 4'b1110); end
    press(9);
    checks++; if (digits !== 12'h002) begin errors++; $display("FAIL run_key_ignored got %h want %h", digits, 12'h002); end
    cancel = 1; tick; cancel = 0;
    checks++; if (ctl !== 4'b1000) begin errors++; $display("FAIL abort_ctl got %b want %b", ctl, 4'b1000); end
    checks++; if (digits !== 12'h000) begin errors++; $display("FAIL abort_digits got %h want %h", digits, 12'h000); end
    tick;
    checks++; if (ctl !== 4'b1000) begin errors++; $display("FAIL abort_no_done got %b want %b", ctl, 4'b1000); end
    press(8);
    checks++; if (digits !== 12'h008) begin errors++; $display("FAIL abort_new_key got %h want %h", digits, 12'h008); end
    cancel = 1; tick; cancel = 0;
  endtask
  task automatic test_midrun_reset;
    press(4);
    start = 1; tick; start = 0;
    chain.timer_zero = 1; tick; chain.timer_zero = 0;
    checks++; if (ctl !== 4'b1110) begin errors++; $display("FAIL load_zero_ignored got %b want %b", ctl, 4'b1110); end
    tick;
    #3 clrn = 0;
    #1;
    checks++; if (ctl !== 4'b1000) begin errors++; $display("FAIL async_reset_ctl got %b want %b", ctl, 4'b1000); end
    checks++; if (digits !== 12'h000) begin errors++; $display("FAIL async_reset_digits got %h want %h", digits, 12'h000); end
    #2 clrn = 1;
    tick;
    checks++; if (ctl !== 4'b1000) begin errors++; $display("FAIL post_reset_ctl got %b want %b", ctl, 4'b1000); end
  endtask
  task automatic test_clamp;
    logic [11:0] exp;
`ifdef LOADER_SEC_CLAMP_EN
    exp = 12'h159;
`else
    exp = 12'h175;
`endif
    press(1); press(7); press(5);
    checks++; if (digits !== 12'h175) begin errors++; $display("FAIL clamp_entry got %h want %h", digits, 12'h175); end
    start = 1; tick; start = 0;
    checks++; if (ctl !== 4'b0010) begin errors++; $display("FAIL clamp_load_ctl got %b want %b", ctl, 4'b0010); end
    checks++; if (digits !== exp) begin errors++; $display("FAIL clamp_digits got %h want %h", digits, exp); end
    tick;
    chain.timer_zero = 1; tick; chain.timer_zero = 0;
    checks++; if (ctl !== 4'b1001) begin errors++; $display("FAIL clamp_done got %b want %b", ctl, 4'b1001); end
    tick;
  endtask
  initial begin
    test_reset;
    test_basic_run;
    test_keys;
    test_guards;
    test_abort;
    test_midrun_reset;
    test_clamp;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
